// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: command and status bundle between the control unit and the PC sequencer.
interface pc_sequencer_if #(parameter int PC_W = 16);
  logic inc, write, jump, Z, jump_abs, loop_set, call, ret, err_clr;
  logic [PC_W-1:0] D, PC_result, loop_start;
  logic stack_full, stack_empty, err;
  modport master (
    output inc, write, jump, Z, jump_abs, loop_set, call, ret, err_clr, D,
    input  PC_result, loop_start, stack_full, stack_empty, err
  );
  modport slave (
    input  inc, write, jump, Z, jump_abs, loop_set, call, ret, err_clr, D,
    output PC_result, loop_start, stack_full, stack_empty, err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with loop register, absolute jumps and a call/return stack.
module pc_sequencer #(
  parameter int PC_W = 16,
  parameter int STACK_DEPTH = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned LOOP_DEFAULT = 3
) (
  input logic Clk,
  input logic Reset,
  pc_sequencer_if.slave bus
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [1:0] rs;
  logic en, full, empty, push, err_q, err_n;
  logic [PC_W-1:0] pc, pc_n, loop_q;
  logic [PC_W-1:0] stk [STACK_DEPTH];
  logic [SP_W-1:0] sp, sp_n, sp_m1;
  assign en = |rs;
  assign full = sp == SP_W'(STACK_DEPTH);
  assign empty = sp == '0;
  assign sp_m1 = sp - SP_W'(1);
  assign bus.PC_result = pc;
  assign bus.loop_start = loop_q;
  assign bus.stack_full = full;
  assign bus.stack_empty = empty;
  assign bus.err = err_q;
  // Reset assert is immediate; release ripples through the shift chain so state starts moving on the second edge.
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) rs <= '0;
    else rs <= {rs[0], 1'b1};
  always_comb begin
    pc_n = pc;
    sp_n = sp;
    push = 1'b0;
    err_n = err_q & ~bus.err_clr;
    if (bus.write) pc_n = bus.D;
    else if (bus.call) begin
      if (!full) begin
        push = 1'b1;
        sp_n = sp + SP_W'(1);
        pc_n = bus.D;
      end else err_n = 1'b1;
    end else if (bus.ret) begin
      if (!empty) begin
        pc_n = stk[sp_m1[IW-1:0]];
        sp_n = sp_m1;
      end else err_n = 1'b1;
    end else if (bus.jump && bus.Z) pc_n = bus.jump_abs ? bus.D : loop_q;
    else if (bus.inc) pc_n = pc + PC_W'(1);
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      pc <= PC_W'(RESET_PC);
      loop_q <= PC_W'(LOOP_DEFAULT);
      sp <= '0;
      err_q <= 1'b0;
    end else if (en) begin
      pc <= pc_n;
      loop_q <= bus.loop_set ? pc : loop_q;
      sp <= sp_n;
      err_q <= err_n;
    end
  always_ff @(posedge Clk)
    if (en && push) stk[sp[IW-1:0]] <= pc + PC_W'(1);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus on 16-bit/depth-4 and 8-bit/depth-2 builds against a priority-rule model.
module tb_pc_sequencer;
  logic Clk = 0, Reset = 1;
  always #5 Clk = ~Clk;
  logic inc, write, jump, Z, jump_abs, loop_set, call, ret, err_clr;
  logic [15:0] D;
  int n_cmp = 0, n_bad = 0;
  pc_sequencer_if #(.PC_W(16)) b16();
  pc_sequencer_if #(.PC_W(8)) b8();
  assign b16.inc = inc;           assign b8.inc = inc;
  assign b16.write = write;       assign b8.write = write;
  assign b16.jump = jump;         assign b8.jump = jump;
  assign b16.Z = Z;               assign b8.Z = Z;
  assign b16.jump_abs = jump_abs; assign b8.jump_abs = jump_abs;
  assign b16.loop_set = loop_set; assign b8.loop_set = loop_set;
  assign b16.call = call;         assign b8.call = call;
  assign b16.ret = ret;           assign b8.ret = ret;
  assign b16.err_clr = err_clr;   assign b8.err_clr = err_clr;
  assign b16.D = D;               assign b8.D = D[7:0];
  pc_sequencer #(.PC_W(16), .STACK_DEPTH(4), .RESET_PC(0), .LOOP_DEFAULT(3))
    u16 (.Clk(Clk), .Reset(Reset), .bus(b16.slave));
  pc_sequencer #(.PC_W(8), .STACK_DEPTH(2), .RESET_PC(0), .LOOP_DEFAULT(3))
    u8 (.Clk(Clk), .Reset(Reset), .bus(b8.slave));
  int unsigned mpc [2], mloop [2], mcnt [2], merr [2], rel;
  int unsigned ms [2][4];
  int unsigned msk [2] = '{32'hFFFF, 32'hFF};
  int unsigned dep [2] = '{4, 2};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_rst();
    for (int k = 0; k < 2; k++) begin
      mpc[k] = 0; mloop[k] = 3; mcnt[k] = 0; merr[k] = 0;
    end
    rel = 0;
  endtask
  task automatic m_edge();
    if (!Reset) begin
      rel = 0;
      return;
    end
    if (rel >= 1)
      for (int k = 0; k < 2; k++) begin
        int unsigned p, m, nerr;
        p = mpc[k]; m = msk[k]; nerr = 0;
        if (write) p = D & m;
        else if (call) begin
          if (mcnt[k] < dep[k]) begin
            ms[k][mcnt[k]] = (mpc[k] + 1) & m;
            mcnt[k]++;
            p = D & m;
          end else nerr = 1;
        end else if (ret) begin
          if (mcnt[k] > 0) begin
            mcnt[k]--;
            p = ms[k][mcnt[k]];
          end else nerr = 1;
        end else if (jump && Z) p = jump_abs ? (D & m) : mloop[k];
        else if (inc) p = (mpc[k] + 1) & m;
        if (loop_set) mloop[k] = mpc[k];
        merr[k] = (nerr != 0 || (merr[k] != 0 && !err_clr)) ? 1 : 0;
        mpc[k] = p;
      end
    rel++;
  endtask
  task automatic compare_all();
    check("pc16", 32'(b16.PC_result), mpc[0]);
    check("loop16", 32'(b16.loop_start), mloop[0]);
    check("full16", 32'(b16.stack_full), 32'(mcnt[0] == 4));
    check("empty16", 32'(b16.stack_empty), 32'(mcnt[0] == 0));
    check("err16", 32'(b16.err), merr[0]);
    check("pc8", 32'(b8.PC_result), mpc[1]);
    check("loop8", 32'(b8.loop_start), mloop[1]);
    check("full8", 32'(b8.stack_full), 32'(mcnt[1] == 2));
    check("empty8", 32'(b8.stack_empty), 32'(mcnt[1] == 0));
    check("err8", 32'(b8.err), merr[1]);
  endtask
  task automatic step();
    @(posedge Clk);
    m_edge();
    #1 compare_all();
  endtask
  task automatic clr();
    {inc, write, jump, Z, jump_abs, loop_set, call, ret, err_clr} = '0;
    D = '0;
  endtask
  task automatic rst_pulse();
    #2 Reset = 0;
    #1 m_rst();
    compare_all();
    check("async_pc", 32'(b16.PC_result), 0);
    check("async_empty", 32'(b16.stack_empty), 1);
    @(negedge Clk) Reset = 1;
    step();
  endtask
  initial begin
    clr();
    m_rst();
    #1 Reset = 0;
    #1 compare_all();
    repeat (3) step();
    @(negedge Clk) Reset = 1;
    inc = 1;
    repeat (4) step();
    rst_pulse();
    inc = 1;
    repeat (5) step();
    check("count5", 32'(b16.PC_result), 5);
    check("loop_rst", 32'(b16.loop_start), 3);
    clr(); write = 1; D = 10; step();
    clr(); loop_set = 1; step();
    check("loop_set", 32'(b16.loop_start), 10);
    clr(); write = 1; D = 14; step();
    clr(); jump = 1; Z = 1; step();
    check("jmp_loop", 32'(b16.PC_result), 10);
    clr(); write = 1; D = 14; step();
    clr(); jump = 1; inc = 1; step();
    check("jmp_nz", 32'(b16.PC_result), 15);
    clr(); jump = 1; Z = 1; jump_abs = 1; D = 16'h0040; step();
    check("jmp_abs", 32'(b16.PC_result), 32'h40);
    clr(); write = 1; D = 16'h0020; step();
    clr(); call = 1; D = 16'h0100; step();
    check("call1", 32'(b16.PC_result), 32'h100);
    D = 16'h0200; step();
    check("call2", 32'(b16.PC_result), 32'h200);
    clr(); ret = 1; step();
    check("ret1", 32'(b16.PC_result), 32'h101);
    step();
    check("ret2", 32'(b16.PC_result), 32'h21);
    clr(); write = 1; D = 16'h0030; step();
    clr(); call = 1;
    for (int i = 0; i < 4; i++) begin
      D = 16'h0101 * 16'(i + 1);
      step();
    end
    check("full4", 32'(b16.stack_full), 1);
    step();
    check("ovf_err", 32'(b16.err), 1);
    check("ovf_pc", 32'(b16.PC_result), 32'h404);
    clr(); ret = 1;
    repeat (4) step();
    check("ret4", 32'(b16.PC_result), 32'h31);
    step();
    check("udf_pc", 32'(b16.PC_result), 32'h31);
    clr(); err_clr = 1; step();
    check("err_clr", 32'(b16.err), 0);
    clr(); write = 1; D = 16'hFFFF; step();
    clr(); inc = 1; step();
    check("wrap", 32'(b16.PC_result), 0);
    clr(); call = 1; D = 16'h0050; step();
    clr(); write = 1; call = 1; ret = 1; jump = 1; Z = 1; D = 16'h0005; step();
    check("prio_wr", 32'(b16.PC_result), 5);
    clr(); ret = 1; step();
    check("prio_ret", 32'(b16.PC_result), 1);
    for (int i = 0; i < 600; i++) begin
      clr();
      write = $urandom_range(7) == 0;
      call = $urandom_range(4) == 0;
      ret = $urandom_range(4) == 0;
      jump = $urandom_range(3) == 0;
      Z = $urandom_range(1) == 1;
      jump_abs = $urandom_range(1) == 1;
      inc = $urandom_range(1) == 1;
      loop_set = $urandom_range(5) == 0;
      err_clr = $urandom_range(9) == 0;
      D = 16'($urandom);
      if (i == 300) rst_pulse();
      else step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program counter for the processor fetch stage.
- Generalises the fixed-width, fixed-loop-target PC. Adds:
  - configurable width;
  - a programmable loop-start register;
  - absolute conditional jumps;
  - a hardware call/return stack with overflow/underflow detection.
- Drives the instruction-memory address every cycle; the control unit drives the command inputs.

Parameters:
- PC_W, 16, PC and address width in bits (≥ 4).
- STACK_DEPTH, 4, return-stack entries (≥ 1).
- RESET_PC, 0, PC value after reset.
- LOOP_DEFAULT, 3, loop-start register value after reset.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous active-low reset.
- inc  input  1  advance PC by 1 when no higher-priority command is active.
- write  input  1  load PC from D.
- jump  input  1  conditional branch request.
- Z  input  1  ALU zero flag; the branch is taken when jump & Z.
- jump_abs  input  1  taken-branch target select: 1 = D, 0 = loop-start register.
- loop_set  input  1  latch current PC into the loop-start register.
- call  input  1  push PC+1 onto the stack, load PC from D.
- ret  input  1  pop the stack into PC.
- err_clr  input  1  clear sticky err.
- D  input  PC_W  load / jump / call target.
- PC_result  output  PC_W  current program counter (registered).
- loop_start  output  PC_W  current loop-start register (registered).
- stack_full  output  1  stack holds STACK_DEPTH entries (combinational from pointer).
- stack_empty  output  1  stack holds 0 entries (combinational from pointer).
- err  output  1  sticky stack overflow/underflow flag (registered).

Behaviour:
- Reset low (asynchronous, immediate):
  - PC_result = RESET_PC, loop_start = LOOP_DEFAULT.
  - Stack pointer = 0, so stack_empty = 1 and stack_full = 0.
  - err = 0. Stack contents don't-care.
- Reset is released synchronously inside the block (two-flop deassert synchroniser). The first update occurs on the second rising edge after Reset rises.
- All updates happen on the rising Clk edge. Each command takes effect on the next edge, so latency is 1 cycle.
- PC command priority, exactly one applied per cycle:
  1. write: PC = D.
  2. call:
     - if not full: stack[sp] = PC+1, sp+1, PC = D;
     - if full: PC and stack unchanged, err = 1.
  3. ret:
     - if not empty: PC = stack[sp-1], sp-1;
     - if empty: PC unchanged, err = 1.
  4. jump & Z: PC = jump_abs ? D : loop_start.
  5. inc: PC = PC+1.
  6. none of the above: PC holds.
- jump with Z=0 is not taken and falls through to inc or hold.
- A lower-priority command asserted together with a higher one is ignored entirely, with no side effects. For example, a simultaneous call and ret performs only the call; the stack does not pop.
- loop_set operates independently of PC priority: loop_start = PC_result as it was before the edge. It can coincide with any PC command.
- Arithmetic is modulo 2^PC_W. For example, PC+1 from all-ones wraps to 0 and pushed return addresses wrap the same way. No flag is raised for wrap.
- Sticky error:
  - err stays set until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, err = 1 (set wins).
- sp width is clog2(STACK_DEPTH+1). It never exceeds STACK_DEPTH and never goes negative.
- A mid-operation reset discards the stack and loop_start immediately. There are no partial commits.

Test Plan:
- Reset low during counting, then release; inc=1 for 5 cycles → PC_result 0,1,2,3,4,5 after synchroniser delay; loop_start=3; stack_empty=1; err=0.
- PC=10, loop_set=1 one cycle; PC=14, jump=1, Z=1, jump_abs=0 → PC=10. Repeat with Z=0 and inc=1 → PC=15. Then jump_abs=1, D=0x0040, Z=1 → PC=0x0040.
- PC=0x0020, call D=0x0100 → PC=0x0100. Nested call D=0x0200 → PC=0x0200. ret → PC=0x0101. ret → PC=0x0021, stack_empty=1.
- STACK_DEPTH=4: 4 calls → stack_full=1. A 5th call → PC unchanged, err=1. 4 rets restore the correct addresses. A 5th ret → err stays 1, PC holds. err_clr → err=0.
- write=1, D=0xFFFF, then inc → PC=0x0000. Simultaneous write D=0x0005, call, ret, jump&Z → PC=0x0005 and sp unchanged.
- PC_W=8, STACK_DEPTH=2 build: wrap 0xFF→0x00 and overflow on the 3rd call. Assert Reset mid-call-sequence → PC=RESET_PC and stack_empty=1 immediately, before the next edge.
